ifetch_ctrl: RTL and testbench
==============================

// Module: ifetch_ctrl
// PURPOSE
// - Fetch-stage sequencer for the LC-3b pipeline. Drives the instruction-memory read handshake and the IR load strobe.
// - Owns the fetch PC. Holds a fetched word while decode stalls.
// - Handles branch/trap redirects, including one that arrives while a memory read is in flight.
// - Sits between instruction memory and the IR register; decode consumes ir_load/ir_data/pc_out.
// PARAMETERS
// - RESET_PC  16'h0000  fetch PC loaded on reset
// - PC_INC    16'd2     PC increment per instruction (byte-addressed 16-bit words)
// PORTS
// - clk           in   1   system clock, all state on posedge
// - reset         in   1   synchronous, active-high reset
// - stall         in   1   decode cannot accept an instruction this cycle
// - redirect      in   1   flush fetch, restart at redirect_pc (1-cycle pulse)
// - redirect_pc   in   16  new fetch target
// - imem_read     out  1   memory read request; held until imem_resp
// - imem_address  out  16  read address; stable while imem_read=1
// - imem_resp     in   1   memory read complete (1-cycle pulse)
// - imem_rdata    in   16  instruction word, valid with imem_resp
// - ir_load       out  1   IR load strobe (combinational, 1 cycle per instruction)
// - ir_data       out  16  word to load into IR, valid when ir_load=1
// - pc_out        out  16  address of the instruction most recently loaded into IR
// - valid_out     out  1   IR holds a live instruction (registered)
// BEHAVIOUR
// - Reset:
//   - state=FETCH, pc=RESET_PC, pc_out=RESET_PC, valid_out=0, hold_buf=0.
//   - imem_read=0 during the reset cycle; ir_load=0.
// - States: FETCH, HOLD, DRAIN. Transitions are listed in priority order.
// - Redirect beats everything except an outstanding memory transaction.
// - FETCH: imem_read=1, imem_address=pc.
//   - redirect & imem_resp: discard rdata; pc<=redirect_pc; stay FETCH; ir_load=0.
//   - redirect & !imem_resp: tgt<=redirect_pc; go DRAIN. The request is never withdrawn mid-transaction.
//   - imem_resp & !stall:
//     - ir_load=1, ir_data=imem_rdata.
//     - pc_out<=pc, pc<=pc+PC_INC, valid_out<=1. Stay FETCH.
//     - Back-to-back: the next request is issued the following cycle.
//   - imem_resp & stall: hold_buf<=imem_rdata; go HOLD; ir_load=0.
//   - No imem_resp: stall is ignored.
// - HOLD: imem_read=0.
//   - redirect: drop hold_buf; pc<=redirect_pc; go FETCH.
//   - !stall:
//     - ir_load=1, ir_data=hold_buf.
//     - pc_out<=pc, pc<=pc+PC_INC, valid_out<=1. Go FETCH.
//   - stall: remain in HOLD, nothing changes.
// - DRAIN: imem_read=1, imem_address=pc (the original address).
//   - redirect in DRAIN: tgt<=redirect_pc (last redirect wins).
//   - imem_resp: discard rdata; pc<=(redirect? redirect_pc : tgt); go FETCH.
// - valid_out:
//   - Cleared (<=0) on any redirect.
//   - Otherwise keeps its value until the next ir_load sets it.
// - PC arithmetic: 16-bit modulo. 16'hFFFE + 2 wraps to 16'h0000 with no flag.
// - ir_data=imem_rdata whenever the state is not HOLD.
// - Reset asserted mid-transaction: state forced to FETCH. The stale imem_resp that follows is treated as the response to the RESET_PC fetch. The memory must itself abort on reset.
// CONFIGURATION
// - IFETCH_PERF_EN defined:
//   - Adds outputs perf_fetch_cnt[15:0] and perf_stall_cnt[15:0].
//   - perf_fetch_cnt increments on each ir_load.
//   - perf_stall_cnt increments on each cycle in HOLD.
//   - Both counters saturate at 16'hFFFF and clear on reset.
// - IFETCH_PERF_EN undefined: the ports and counters are absent; behaviour is otherwise identical.
// TESTING
// - Reset with RESET_PC=16'h0000, then 3 fetches with 2-cycle memory latency, stall=0:
//   - imem_address sequence 0000,0002,0004.
//   - 3 ir_load pulses; pc_out=0004; valid_out=1.
// - imem_resp with rdata=16'h1234 while stall=1 for 4 cycles:
//   - HOLD; imem_read=0 for 4 cycles.
//   - On stall release: ir_load=1 with ir_data=1234, then the next request is at pc+2.
// - redirect to 16'h3000 two cycles into a 5-cycle read of 16'h0010:
//   - imem_address stays 0010 until imem_resp.
//   - That rdata is discarded (no ir_load).
//   - The next request is at 3000; valid_out=0 until the 3000 response.
// - redirect to 16'h4000 in HOLD: buffered word dropped, no ir_load; next imem_address=4000.
// - pc=16'hFFFE fetched: pc wraps to 0000; next imem_address=0000.
// - IFETCH_PERF_EN: 5 loads plus 3 HOLD cycles -> perf_fetch_cnt=5, perf_stall_cnt=3. Reset -> both 0.

Source files
------------

// File: rtl/ifetch_ctrl.sv
// Purpose : LC-3b fetch-stage sequencer; owns the fetch PC, drives the imem read handshake and the IR load strobe.
// Latency : ir_load is combinational from imem_resp; a new request is issued the cycle after a word is consumed.
// Backpressure: stall parks the returned word in a one-entry hold buffer (imem_read drops) until decode accepts it.
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   stall                      decode cannot take an instruction this cycle
//   redirect, redirect_pc      one-cycle flush request and its new fetch target
//   imem_read, imem_address    read request to instruction memory, held until imem_resp
//   imem_resp, imem_rdata      one-cycle read completion and its instruction word
//   ir_load, ir_data           IR load strobe and the word to load
//   pc_out, valid_out          address of the word last loaded into IR, IR-holds-live-instruction flag
//
// Optional feature: define IFETCH_PERF_EN to add saturating perf_fetch_cnt / perf_stall_cnt outputs.

module ifetch_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_INC   = 16'd2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_read,
    output logic [15:0] imem_address,
    input  logic        imem_resp,
    input  logic [15:0] imem_rdata,
    output logic        ir_load,
    output logic [15:0] ir_data,
    output logic [15:0] pc_out,
    output logic        valid_out
`ifdef IFETCH_PERF_EN
    ,
    output logic [15:0] perf_fetch_cnt,
    output logic [15:0] perf_stall_cnt
`endif
);

    // FETCH : request outstanding at pc_q
    // HOLD  : word returned while decode stalled, parked in hold_buf_q
    // DRAIN : redirect arrived mid-read; wait out the read, then jump to tgt_q
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e      state_q,    state_d;
    logic [15:0] pc_q,       pc_d;
    logic [15:0] pc_out_q,   pc_out_d;
    logic        valid_q,    valid_d;
    logic [15:0] hold_buf_q, hold_buf_d;
    logic [15:0] tgt_q,      tgt_d;

    // Asserted when a word (from memory or from the hold buffer) goes to IR.
    logic        load_fire;

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_out_d   = pc_out_q;
        valid_d    = valid_q;
        hold_buf_d = hold_buf_q;
        tgt_d      = tgt_q;
        load_fire  = 1'b0;
        imem_read  = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                imem_read = 1'b1;
                if (redirect) begin
                    valid_d = 1'b0;
                    if (imem_resp) begin
                        // Read completes in the same cycle: its word is stale,
                        // restart straight away at the new target.
                        pc_d = redirect_pc;
                    end else begin
                        // Memory is mid-read; the request cannot be withdrawn,
                        // so remember the target and let the read finish.
                        tgt_d   = redirect_pc;
                        state_d = S_DRAIN;
                    end
                end else if (imem_resp) begin
                    if (!stall) begin
                        load_fire = 1'b1;
                    end else begin
                        hold_buf_d = imem_rdata;
                        state_d    = S_HOLD;
                    end
                end
                // Without a response, stall has no effect in this state.
            end

            S_HOLD: begin
                if (redirect) begin
                    hold_buf_d = 16'h0000;
                    pc_d       = redirect_pc;
                    valid_d    = 1'b0;
                    state_d    = S_FETCH;
                end else if (!stall) begin
                    load_fire = 1'b1;
                    state_d   = S_FETCH;
                end
            end

            S_DRAIN: begin
                // Address stays at the original pc until the read completes.
                imem_read = 1'b1;
                if (redirect) begin
                    tgt_d   = redirect_pc;
                    valid_d = 1'b0;
                end
                if (imem_resp) begin
                    // A redirect in the completing cycle overrides the stored
                    // target, since tgt_q has not yet captured it.
                    pc_d    = redirect ? redirect_pc : tgt_q;
                    state_d = S_FETCH;
                end
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (load_fire) begin
            pc_out_d = pc_q;
            pc_d     = pc_q + PC_INC;   // 16-bit modulo wrap
            valid_d  = 1'b1;
        end

        // Nothing leaves the block while reset is held.
        if (reset) begin
            imem_read = 1'b0;
            load_fire = 1'b0;
        end
    end

    assign ir_load      = load_fire;
    assign ir_data      = (state_q == S_HOLD) ? hold_buf_q : imem_rdata;
    assign imem_address = pc_q;
    assign pc_out       = pc_out_q;
    assign valid_out    = valid_q;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            pc_out_q   <= RESET_PC;
            valid_q    <= 1'b0;
            hold_buf_q <= 16'h0000;
            tgt_q      <= 16'h0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_out_q   <= pc_out_d;
            valid_q    <= valid_d;
            hold_buf_q <= hold_buf_d;
            tgt_q      <= tgt_d;
        end
    end

`ifdef IFETCH_PERF_EN
    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    logic [15:0] perf_fetch_cnt_q, perf_fetch_cnt_d;
    logic [15:0] perf_stall_cnt_q, perf_stall_cnt_d;

    always_comb begin
        perf_fetch_cnt_d = perf_fetch_cnt_q;
        perf_stall_cnt_d = perf_stall_cnt_q;
        if (load_fire && (perf_fetch_cnt_q != 16'hFFFF)) begin
            perf_fetch_cnt_d = perf_fetch_cnt_q + 16'd1;
        end
        if ((state_q == S_HOLD) && (perf_stall_cnt_q != 16'hFFFF)) begin
            perf_stall_cnt_d = perf_stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_cnt_q <= 16'h0000;
            perf_stall_cnt_q <= 16'h0000;
        end else begin
            perf_fetch_cnt_q <= perf_fetch_cnt_d;
            perf_stall_cnt_q <= perf_stall_cnt_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_cnt_q;
    assign perf_stall_cnt = perf_stall_cnt_q;
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Purpose : self-checking bench for ifetch_ctrl (directed vector table, hand sequences, random vs. reference model).
// Latency : inputs driven at negedge, outputs sampled 1 time unit later, state advances at posedge.
// Backpressure: memory responses are only offered while the reference model expects a read request.

module tb_ifetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_read;
    logic [15:0] imem_address;
    logic        imem_resp;
    logic [15:0] imem_rdata;
    logic        ir_load;
    logic [15:0] ir_data;
    logic [15:0] pc_out;
    logic        valid_out;
`ifdef IFETCH_PERF_EN
    logic [15:0] perf_fetch_cnt;
    logic [15:0] perf_stall_cnt;
`endif

    ifetch_ctrl #(
        .RESET_PC (16'h0000),
        .PC_INC   (16'd2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_read    (imem_read),
        .imem_address (imem_address),
        .imem_resp    (imem_resp),
        .imem_rdata   (imem_rdata),
        .ir_load      (ir_load),
        .ir_data      (ir_data),
        .pc_out       (pc_out),
        .valid_out    (valid_out)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: drive at negedge, settle, caller samples.
    task automatic drive(input logic s, input logic r, input logic [15:0] rpc,
                         input logic rsp, input logic [15:0] rd);
        @(negedge clk);
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        imem_resp   = rsp;
        imem_rdata  = rd;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
        imem_resp = 1'b0; imem_rdata = 16'h0;
        @(negedge clk);
        // A response during reset must not produce an IR load.
        imem_resp = 1'b1; imem_rdata = 16'hABCD;
        #1;
        chk1("reset_imem_read", imem_read, 1'b0);
        chk1("reset_ir_load",   ir_load,   1'b0);
        @(negedge clk);
        reset = 1'b0; imem_resp = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Directed vector table: one record per cycle
    // ------------------------------------------------------------------
    typedef struct {
        logic        s;
        logic        r;
        logic [15:0] rpc;
        logic        rsp;
        logic [15:0] rd;
        logic        e_read;
        logic [15:0] e_addr;
        logic        e_load;
        logic [15:0] e_data;
        logic [15:0] e_pco;
        logic        e_valid;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic s, logic r, logic [15:0] rpc, logic rsp, logic [15:0] rd,
                                logic e_read, logic [15:0] e_addr, logic e_load,
                                logic [15:0] e_data, logic [15:0] e_pco, logic e_valid);
        vec_t v;
        v.s = s; v.r = r; v.rpc = rpc; v.rsp = rsp; v.rd = rd;
        v.e_read = e_read; v.e_addr = e_addr; v.e_load = e_load;
        v.e_data = e_data; v.e_pco = e_pco; v.e_valid = e_valid;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: fetch PC plus queues for a parked word and for
    // redirect targets waiting on an in-flight read.
    // ------------------------------------------------------------------
    logic [15:0] m_pc, m_pco;
    logic        m_valid;
    logic [15:0] m_held[$];
    logic [15:0] m_tgt[$];

    initial begin
        logic        s, r, rsp, e_rd, e_ld, in_hold, draining;
        logic [15:0] rpc, rd, e_dat;
        string       nm;

        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
        imem_resp = 1'b0; imem_rdata = 16'h0;

        //          s  r  rpc       rsp rd        read addr     ld dat       pc_out    valid
        vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 16'hA000, 1, 16'h0000, 1, 16'hA000, 16'h0000, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0002, 0, 16'h0000, 16'h0000, 1));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 16'hA002, 1, 16'h0002, 1, 16'hA002, 16'h0000, 1));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0004, 0, 16'h0000, 16'h0002, 1));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 16'hA004, 1, 16'h0004, 1, 16'hA004, 16'h0002, 1));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0006, 0, 16'h0000, 16'h0004, 1));
        // response under stall -> HOLD for 4 cycles, then release
        vecs.push_back(mk(1, 0, 16'h0000, 1, 16'h1234, 1, 16'h0006, 0, 16'h1234, 16'h0004, 1));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h1234, 16'h0004, 1));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h1234, 16'h0004, 1));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0008, 0, 16'h0000, 16'h0006, 1));
        // redirect coincident with a response -> restart at 0010
        vecs.push_back(mk(0, 1, 16'h0010, 1, 16'hDEAD, 1, 16'h0008, 0, 16'hDEAD, 16'h0006, 1));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0010, 0, 16'h0000, 16'h0006, 0));
        // redirect two cycles into a 5-cycle read of 0010
        vecs.push_back(mk(0, 1, 16'h3000, 0, 16'h0000, 1, 16'h0010, 0, 16'h0000, 16'h0006, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0010, 0, 16'h0000, 16'h0006, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0010, 0, 16'h0000, 16'h0006, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 16'hBEEF, 1, 16'h0010, 0, 16'hBEEF, 16'h0006, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h3000, 0, 16'h0000, 16'h0006, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 16'hC300, 1, 16'h3000, 1, 16'hC300, 16'h0006, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h3002, 0, 16'h0000, 16'h3000, 1));
        // redirect while holding a word -> word dropped
        vecs.push_back(mk(1, 0, 16'h0000, 1, 16'h5555, 1, 16'h3002, 0, 16'h5555, 16'h3000, 1));
        vecs.push_back(mk(1, 1, 16'h4000, 0, 16'h0000, 0, 16'h0000, 0, 16'h5555, 16'h3000, 1));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h4000, 0, 16'h0000, 16'h3000, 0));
        // fetch at FFFE wraps the PC to 0000
        vecs.push_back(mk(0, 1, 16'hFFFE, 1, 16'h1111, 1, 16'h4000, 0, 16'h1111, 16'h3000, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h7777, 1, 16'hFFFE, 1, 16'h7777, 16'h3000, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'hFFFE, 1));
        // two redirects during one read: the last one wins
        vecs.push_back(mk(0, 1, 16'h1000, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'hFFFE, 1));
        vecs.push_back(mk(0, 1, 16'h2000, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'hFFFE, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h3333, 1, 16'h0000, 0, 16'h3333, 16'hFFFE, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h2000, 0, 16'h0000, 16'hFFFE, 0));
        // stall without a response is ignored
        vecs.push_back(mk(1, 0, 16'h0000, 0, 16'h0000, 1, 16'h2000, 0, 16'h0000, 16'hFFFE, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h2000, 0, 16'h0000, 16'hFFFE, 0));

        // ---------------- reset state ----------------
        do_reset();
        #1;
        chk16("post_reset_pc_out", pc_out, 16'h0000);
        chk1 ("post_reset_valid",  valid_out, 1'b0);

        // ---------------- directed table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].s, vecs[i].r, vecs[i].rpc, vecs[i].rsp, vecs[i].rd);
            nm = $sformatf("vec%0d", i);
            chk1 ({nm, "_imem_read"}, imem_read, vecs[i].e_read);
            if (vecs[i].e_read)
                chk16({nm, "_imem_address"}, imem_address, vecs[i].e_addr);
            chk1 ({nm, "_ir_load"}, ir_load, vecs[i].e_load);
            chk16({nm, "_ir_data"}, ir_data, vecs[i].e_data);
            chk16({nm, "_pc_out"},  pc_out,  vecs[i].e_pco);
            chk1 ({nm, "_valid_out"}, valid_out, vecs[i].e_valid);
        end

        // ---------------- reset while draining ----------------
        drive(0, 1, 16'h5000, 0, 16'h0000);          // FETCH at 2000 -> DRAIN
        @(negedge clk);
        reset = 1'b1; redirect = 1'b0; imem_resp = 1'b0;
        #1;
        chk1("rst_mid_imem_read", imem_read, 1'b0);
        chk1("rst_mid_ir_load",   ir_load,   1'b0);
        @(negedge clk);
        reset = 1'b0;
        imem_resp = 1'b1; imem_rdata = 16'h9999;     // stale response taken as the RESET_PC fetch
        #1;
        chk16("rst_mid_addr",    imem_address, 16'h0000);
        chk1 ("rst_mid_load",    ir_load, 1'b1);
        chk16("rst_mid_data",    ir_data, 16'h9999);
        drive(0, 0, 16'h0000, 0, 16'h0000);
        chk16("rst_mid_pc_out",  pc_out, 16'h0000);
        chk1 ("rst_mid_valid",   valid_out, 1'b1);
        chk16("rst_mid_next",    imem_address, 16'h0002);

`ifdef IFETCH_PERF_EN
        // ---------------- performance counters ----------------
        do_reset();
        #1;
        chk16("perf_fetch_reset", perf_fetch_cnt, 16'h0000);
        chk16("perf_stall_reset", perf_stall_cnt, 16'h0000);
        drive(1, 0, 16'h0000, 1, 16'hAAAA);          // enter HOLD
        drive(1, 0, 16'h0000, 0, 16'h0000);          // HOLD cycle 1
        drive(1, 0, 16'h0000, 0, 16'h0000);          // HOLD cycle 2
        drive(0, 0, 16'h0000, 0, 16'h0000);          // HOLD cycle 3, load 1
        for (int i = 0; i < 4; i++)
            drive(0, 0, 16'h0000, 1, 16'h0100);      // loads 2..5
        drive(0, 0, 16'h0000, 0, 16'h0000);
        chk16("perf_fetch_cnt", perf_fetch_cnt, 16'd5);
        chk16("perf_stall_cnt", perf_stall_cnt, 16'd3);
        do_reset();
        #1;
        chk16("perf_fetch_clr", perf_fetch_cnt, 16'h0000);
        chk16("perf_stall_clr", perf_stall_cnt, 16'h0000);
`endif

        // ---------------- randomized run vs. reference model ----------------
        do_reset();
        m_pc = 16'h0000; m_pco = 16'h0000; m_valid = 1'b0;
        m_held.delete(); m_tgt.delete();
        for (int c = 0; c < 3000; c++) begin
            in_hold  = (m_held.size() != 0);
            draining = (m_tgt.size() != 0);
            e_rd     = !in_hold;
            s   = ($urandom % 3) == 0;
            r   = ($urandom % 8) == 0;
            rpc = 16'($urandom) & 16'hFFFE;
            rsp = e_rd && (($urandom % 3) == 0);
            rd  = 16'($urandom);
            drive(s, r, rpc, rsp, rd);

            e_ld  = in_hold ? (!r && !s) : (!draining && rsp && !r && !s);
            e_dat = in_hold ? m_held[0] : rd;
            chk1("rnd_imem_read", imem_read, e_rd);
            if (e_rd)
                chk16("rnd_imem_address", imem_address, m_pc);
            chk1 ("rnd_ir_load", ir_load, e_ld);
            if (e_ld)
                chk16("rnd_ir_data", ir_data, e_dat);
            chk16("rnd_pc_out", pc_out, m_pco);
            chk1 ("rnd_valid_out", valid_out, m_valid);

            // advance the model across the clock edge
            if (in_hold) begin
                if (r) begin
                    m_held.delete(); m_pc = rpc; m_valid = 1'b0;
                end else if (!s) begin
                    m_held.delete(); m_pco = m_pc; m_pc = m_pc + 16'd2; m_valid = 1'b1;
                end
            end else if (draining) begin
                if (r) begin
                    m_tgt.push_back(rpc); m_valid = 1'b0;
                end
                if (rsp) begin
                    m_pc = m_tgt[$]; m_tgt.delete();
                end
            end else begin
                if (r) begin
                    m_valid = 1'b0;
                    if (rsp) m_pc = rpc;
                    else     m_tgt.push_back(rpc);
                end else if (rsp) begin
                    if (s) m_held.push_back(rd);
                    else begin
                        m_pco = m_pc; m_pc = m_pc + 16'd2; m_valid = 1'b1;
                    end
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
